// File: rtl/matmul_apb_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// matmul_apb_master
//
// APB requester for the matmul slave port. A simple valid/ready command
// interface is turned into one APB transfer (SETUP then ACCESS); the result
// comes back as a single-cycle response pulse carrying read data and an error
// flag. Only one transfer is in flight at a time.
//
// A write that would set the start bit of the control register (address
// offset 0x00, wdata[0] = 1) is held off while the accelerator reports busy;
// the command stays pending on the request interface until busy_i falls.
//
// Optional feature (macro APB_TIMEOUT_EN): an ACCESS-phase wait counter that
// aborts a transfer after TIMEOUT_CYCLES wait cycles and returns an error
// response. Without the macro ACCESS waits for pready_i indefinitely.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o  command handshake
//   req_write_i          1 = write, 0 = read
//   req_addr_i           target address
//   req_wdata_i          write data
//   req_strb_i           write strobes (MAX_DIM bits)
//   rsp_valid_o          one-cycle response pulse, no backpressure
//   rsp_rdata_o          read data (0 for writes)
//   rsp_err_o            slave error or timeout
//   busy_i               accelerator busy
//   paddr_o .. pstrb_o   APB requester outputs
//   pready_i, pslverr_i, prdata_i  APB completer inputs
// -----------------------------------------------------------------------------
module matmul_apb_master #(
  parameter int DATA_WIDTH     = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15,
  localparam int MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [BUS_WIDTH-1:0]  req_wdata_i,
  input  logic [MAX_DIM-1:0]    req_strb_i,

  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,

  input  logic                  busy_i,

  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic start_hold;   // start-bit write must wait for the accelerator
  logic accept;       // command consumed this cycle
  logic done;         // ACCESS completed by the completer
  logic abort;        // ACCESS abandoned by the timeout
  logic timeout_hit;

  assign start_hold = req_valid_i & req_write_i &
                      (req_addr_i[4:0] == 5'b00000) &
                      req_wdata_i[0] & busy_i;

  // APB strobes follow the state directly so that an asynchronous reset
  // drops them in the same instant.
  assign psel_o    = (state_q != ST_IDLE);
  assign penable_o = (state_q == ST_ACCESS);

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = ~start_hold;
        accept      = req_valid_i & ~start_hold;
        if (accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A completion in the same cycle as the timeout takes precedence.
        if (pready_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: the APB address/data/control hold their last values
  // outside a transfer. Reads drive zero data and zero strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else if (accept) begin
      paddr_o  <= req_addr_i;
      pwrite_o <= req_write_i;
      pwdata_o <= req_write_i ? req_wdata_i : '0;
      pstrb_o  <= req_write_i ? req_strb_i  : '0;
    end
  end

  // Response: pulse one cycle after the ACCESS phase ends; data and error
  // hold until the next response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= done | abort;
      if (done) begin
        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
        rsp_err_o   <= pslverr_i;
      end else if (abort) begin
        rsp_rdata_o <= '0;
        rsp_err_o   <= 1'b1;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Cleared while in SETUP so it starts from zero on ACCESS entry; the abort
  // fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_ACCESS) && !pready_i) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_param;

  assign timeout_hit          = 1'b0;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_matmul_apb_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_matmul_apb_master
//
// Directed plus randomized bench for matmul_apb_master. The bench plays the
// APB completer itself (choosing wait states, read data and error per
// transfer) and derives every expected value from the transfer description.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_matmul_apb_master;

  localparam int DW = 8;
  localparam int BW = 32;
  localparam int AW = 32;
  localparam int SW = BW / DW;
  localparam int TMO = 15;

  logic          clk;
  logic          rst_ni;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid;
  logic [BW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [BW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready;
  logic          pslverr;
  logic [BW-1:0] prdata;

  int n_vec = 0;
  int n_err = 0;

  matmul_apb_master #(
    .DATA_WIDTH    (DW),
    .BUS_WIDTH     (BW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_strb_i (req_strb),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .busy_i     (busy),
    .paddr_o    (paddr),
    .psel_o     (psel),
    .penable_o  (penable),
    .pwrite_o   (pwrite),
    .pwdata_o   (pwdata),
    .pstrb_o    (pstrb),
    .pready_i   (pready),
    .pslverr_i  (pslverr),
    .prdata_i   (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer. waits = ACCESS cycles with pready low before the
  // completing cycle; busy_cyc = cycles a start-bit write is held off first.
  task automatic xfer(input bit wr, input logic [AW-1:0] addr,
                      input logic [BW-1:0] wdata, input logic [SW-1:0] strb,
                      input int waits, input logic [BW-1:0] rdata,
                      input bit slverr, input int busy_cyc);
    logic [BW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    logic [BW-1:0] exp_rdata;
    exp_pwdata = wr ? wdata : '0;
    exp_pstrb  = wr ? strb  : '0;
    exp_rdata  = wr ? '0    : rdata;

    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    pready    = 1'b0;
    busy      = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      #1;
      chk("guard_ready", req_ready, 0);
      chk("guard_psel", psel, 0);
      @(negedge clk);
    end
    busy = 1'b0;
    #1;
    chk("req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    // Scramble the request after acceptance to prove the fields were latched.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_strb  = SW'($urandom);

    // SETUP: completer signals are don't-care here.
    @(negedge clk);
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    #1;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_ready", req_ready, 0);
    chk("paddr", paddr, addr);
    chk("pwrite", pwrite, wr);
    chk("pwdata", pwdata, exp_pwdata);
    chk("pstrb", pstrb, exp_pstrb);

    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      pready  = (k == waits);
      pslverr = (k == waits) ? slverr : 1'($urandom);
      prdata  = (k == waits) ? rdata  : $urandom;
      #1;
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, addr);
      chk("access_pwdata", pwdata, exp_pwdata);
      chk("rsp_idle", rsp_valid, 0);
    end

    @(negedge clk);
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_err", rsp_err, slverr);
    chk("done_psel", psel, 0);
    chk("done_penable", penable, 0);
    chk("done_ready", req_ready, 1);

    @(negedge clk);
    pready = 1'b0;
    #1;
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_hold", rsp_rdata, exp_rdata);
    chk("paddr_hold", paddr, addr);
  endtask

  initial begin
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    busy      = 1'b0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("idle_ready", req_ready, 1);

    // Guard only applies to a start-bit write at offset 0 while busy.
    @(negedge clk);
    busy = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    req_addr = 32'h0000_0000; req_wdata = 32'h0000_1500;
    #1; chk("noguard_bit0", req_ready, 1);
    req_addr = 32'h0000_0004; req_wdata = 32'h0000_0001;
    #1; chk("noguard_addr", req_ready, 1);
    req_addr = 32'h0000_0000; req_write = 1'b0;
    #1; chk("noguard_read", req_ready, 1);
    req_write = 1'b1;
    #1; chk("guard_on", req_ready, 0);
    req_valid = 1'b0; busy = 1'b0;

    // Directed transfers
    xfer(1'b1, 32'h04, 32'h0003_0001, 4'b0011, 0, 32'h0, 1'b0, 0);
    xfer(1'b0, 32'h10, 32'h0,         4'b0000, 3, 32'h0000_00AB, 1'b0, 0);
    xfer(1'b1, 32'h00, 32'h0000_1501, 4'b0001, 0, 32'h0, 1'b0, 5);
    xfer(1'b0, 32'h18, 32'h0,         4'b0000, 1, 32'hDEAD_BEEF, 1'b1, 0);
    xfer(1'b0, 32'h18, 32'h0,         4'b0000, 0, 32'h1234_5678, 1'b0, 0);
    xfer(1'b1, 32'h20, 32'hCAFE_0001, 4'b1111, 2, 32'h5555_AAAA, 1'b1, 0);
`ifdef APB_TIMEOUT_EN
    // Ready on the last allowed wait cycle still completes normally.
    xfer(1'b0, 32'h30, 32'h0, 4'b0000, TMO - 1, 32'h0000_0077, 1'b0, 0);
`else
    // Without the timeout a long wait is simply tolerated.
    xfer(1'b0, 32'h30, 32'h0, 4'b0000, 25, 32'h0000_0077, 1'b0, 0);
`endif

    // Randomized transfers
    for (int t = 0; t < 16; t++) begin
      xfer(1'($urandom), $urandom, $urandom, SW'($urandom),
           $urandom_range(0, 4), $urandom, 1'($urandom), 0);
    end

`ifdef APB_TIMEOUT_EN
    begin
      int acc;
      acc = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h44;
      pready = 1'b0; prdata = 32'hFFFF_FFFF; pslverr = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 60 && !rsp_valid; c++) begin
        @(negedge clk); #1;
        if (penable) acc++;
      end
      chk("tmo_rsp_valid", rsp_valid, 1);
      chk("tmo_access_cycles", acc, TMO);
      chk("tmo_err", rsp_err, 1);
      chk("tmo_rdata", rsp_rdata, 0);
      chk("tmo_psel", psel, 0);
      chk("tmo_ready", req_ready, 1);
    end
`endif

    // Reset in the middle of ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h28;
    pready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);      // SETUP
    @(negedge clk);      // ACCESS
    #1;
    chk("pre_rst_penable", penable, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    pready = 1'b1; prdata = 32'h0BAD_0BAD;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_psel", psel, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
    pready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matmul_apb_master.md
Name: matmul_apb_master

Overview:
- APB requester that drives the matmul slave port from a simple valid/ready command interface. Used by the bench-side sequencer or an on-chip controller.
- Sequences the SETUP and ACCESS phases and returns read data and error status as a one-cycle response.
- Holds back a start-bit write to the control register while the accelerator reports busy.
- One transfer outstanding at a time.

Parameters:
- DATA_WIDTH, 16, element width; legal values 8/16/32. Used only to derive the strobe width.
- BUS_WIDTH, 32, APB data width; legal values 16/32/64.
- ADDR_WIDTH, 32, APB address width; legal values 16/24/32.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, localparam; sets the strobe width.
- TIMEOUT_CYCLES, 15, number of ACCESS wait cycles before abort. Used only with APB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when high together with req_valid_i.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  target address.
- req_wdata_i  in  BUS_WIDTH  write data.
- req_strb_i  in  MAX_DIM  write strobes.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  BUS_WIDTH  read data; 0 for writes.
- rsp_err_o  out  1  slave error or timeout.
- busy_i  in  1  accelerator busy (matmul busy_o).
- paddr_o  out  ADDR_WIDTH  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction.
- pwdata_o  out  BUS_WIDTH  APB write data.
- pstrb_o  out  MAX_DIM  APB strobes.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB error.
- prdata_i  in  BUS_WIDTH  APB read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Reset asserted mid-transfer: psel_o and penable_o drop immediately, and no response is produced for the aborted command.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready_o = 1 unless the start guard applies.
  - On req_valid_i & req_ready_o, latch write/addr/wdata/strb into paddr_o, pwrite_o, pwdata_o, pstrb_o.
  - For reads, pwdata_o = 0 and pstrb_o = 0.
  - Next state SETUP.
- Start guard: req_ready_o = 0 while all of the following hold. The command is not consumed and stays pending until busy_i falls.
  - req_valid_i = 1
  - req_write_i = 1
  - req_addr_i[4:0] = 5'b00000
  - req_wdata_i[0] = 1
  - busy_i = 1
- req_ready_o is combinational from state, the request fields and busy_i; req_ready_o = 0 in SETUP and ACCESS.
- SETUP: psel_o = 1, penable_o = 0; unconditional move to ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - Address, data, strobe and direction are held stable.
  - Wait while pready_i = 0.
  - On pready_i = 1: register rsp_rdata_o (prdata_i for reads, 0 for writes) and rsp_err_o = pslverr_i. Pulse rsp_valid_o for one cycle on the next cycle, drop psel_o and penable_o, return to IDLE.
- Latency with zero wait states:
  - accept edge → SETUP cycle 1 → ACCESS cycle 2 → rsp_valid_o in cycle 3.
  - Next command can be accepted in cycle 3, so throughput is 1 transfer per 3 cycles.
- Outside a transfer: paddr_o, pwrite_o, pwdata_o and pstrb_o hold their last values. rsp_rdata_o and rsp_err_o hold until the next response.
- pslverr_i is sampled only when psel_o & penable_o & pready_i; it is ignored at all other times.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i = 0.
  - When the count reaches TIMEOUT_CYCLES with pready_i still low: abort, drop psel_o and penable_o, pulse rsp_valid_o next cycle with rsp_err_o = 1 and rsp_rdata_o = 0, return to IDLE.
  - If pready_i = 1 arrives in the same cycle the count reaches TIMEOUT_CYCLES, normal completion wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter is built, and ACCESS waits indefinitely for pready_i.

Test Plan:
- Write addr 0x04 data 0x0003_0001, strb 4'b0011, pready_i tied high → SETUP cycle 1 (psel=1, penable=0); ACCESS cycle 2; rsp_valid_o=1 in cycle 3 with rsp_err_o=0, rsp_rdata_o=0.
- Read addr 0x10, pready_i low for 3 ACCESS cycles, prdata_i=0x0000_00AB → penable_o high for 4 cycles with paddr_o stable; rsp_rdata_o=0xAB.
- Write addr 0x00 data 0x0000_1501 while busy_i=1 for 5 cycles → req_ready_o=0 and psel_o=0 for those cycles; transfer starts the cycle after busy_i falls.
- Read whose completion has pslverr_i=1 → rsp_err_o=1; a following clean read returns rsp_err_o=0.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=15, pready_i held low → abort after 15 wait cycles with rsp_err_o=1, rsp_rdata_o=0, back in IDLE.
- Assert rst_ni low during ACCESS → psel_o, penable_o and rsp_valid_o are 0 immediately; after reset release req_ready_o=1.
